// File: rtl/bk_adder_pipe.sv
// bk_adder_pipe: three-stage pipelined Brent-Kung adder/subtractor with valid/ready flow control
module bk_adder_pipe #(
    parameter int WIDTH = 12,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic [TAG_W-1:0] out_tag
);
    // The carry-in occupies prefix position 0, so the tree spans WIDTH+1 leaves padded to a power of two.
    localparam int N = 2 ** $clog2(WIDTH + 1);
    localparam int L = $clog2(N);

    logic             v1_q, v2_q, v3_q;
    logic             adv1, adv2, adv3;
    logic [WIDTH-1:0] b_x, g1_d, p1_d, g1_q, p1_q;
    logic             c01_d, c01_q, am1_q, bm1_q;
    logic [TAG_W-1:0] tag1_q, tag2_q, tag3_q;
    logic [N-1:0]     gg, pp;
    logic [WIDTH:0]   c2_d, c2_q;
    logic [WIDTH-1:0] p2_q;
    logic             am2_q, bm2_q;
    logic [WIDTH-1:0] sum_d, sum3_q;
    logic             cout_d, ovf_d, cout3_q, ovf3_q;

    assign adv3      = ~v3_q | out_ready;
    assign adv2      = ~v2_q | adv3;
    assign adv1      = ~v1_q | adv2;
    assign in_ready  = adv1;
    assign out_valid = v3_q;
    assign out_sum   = sum3_q;
    assign out_cout  = cout3_q;
    assign out_ovf   = ovf3_q;
    assign out_tag   = tag3_q;

    // Operand conditioning: subtraction inverts B and forces the carry-in.
    always_comb begin
        b_x   = in_sub ? ~in_b : in_b;
        g1_d  = in_a & b_x;
        p1_d  = in_a ^ b_x;
        c01_d = in_sub | in_cin;
    end

    // Stage 1 register: generate/propagate, carry-in, MSBs and tag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q   <= 1'b0;
            g1_q   <= '0;
            p1_q   <= '0;
            c01_q  <= 1'b0;
            am1_q  <= 1'b0;
            bm1_q  <= 1'b0;
            tag1_q <= '0;
        end else begin
            if (adv1) v1_q <= in_valid;
            if (adv1 && in_valid) begin
                g1_q   <= g1_d;
                p1_q   <= p1_d;
                c01_q  <= c01_d;
                am1_q  <= in_a[WIDTH-1];
                bm1_q  <= b_x[WIDTH-1];
                tag1_q <= in_tag;
            end
        end
    end

    // Brent-Kung prefix tree: up-sweep builds power-of-two spans, down-sweep fills the gaps.
    always_comb begin
        gg          = '0;
        pp          = '0;
        gg[0]       = c01_q;
        gg[WIDTH:1] = g1_q;
        pp[WIDTH:1] = p1_q;
        for (int l = 0; l < L; l++) begin
            for (int i = 0; i < N; i++) begin
                if (((i + 1) % (1 << (l + 1))) == 0) begin
                    gg[i] = gg[i] | (pp[i] & gg[i - (1 << l)]);
                    pp[i] = pp[i] & pp[i - (1 << l)];
                end
            end
        end
        for (int l = L - 2; l >= 0; l--) begin
            for (int i = 0; i < N; i++) begin
                if ((((i + 1) % (1 << (l + 1))) == (1 << l)) && (i >= (1 << (l + 1)))) begin
                    gg[i] = gg[i] | (pp[i] & gg[i - (1 << l)]);
                    pp[i] = pp[i] & pp[i - (1 << l)];
                end
            end
        end
        c2_d = gg[WIDTH:0];
    end

    // Stage 2 register: all carries plus forwarded propagate, MSBs and tag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2_q   <= 1'b0;
            c2_q   <= '0;
            p2_q   <= '0;
            am2_q  <= 1'b0;
            bm2_q  <= 1'b0;
            tag2_q <= '0;
        end else begin
            if (adv2) v2_q <= v1_q;
            if (adv2 && v1_q) begin
                c2_q   <= c2_d;
                p2_q   <= p1_q;
                am2_q  <= am1_q;
                bm2_q  <= bm1_q;
                tag2_q <= tag1_q;
            end
        end
    end

    // Final sum; overflow when both effective operands share a sign the result does not (same as c[W]^c[W-1]).
    always_comb begin
        sum_d  = p2_q ^ c2_q[WIDTH-1:0];
        cout_d = c2_q[WIDTH];
        ovf_d  = (am2_q == bm2_q) & (sum_d[WIDTH-1] ^ am2_q);
    end

    // Stage 3 output register; holds while stalled and reads zero until the first result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v3_q    <= 1'b0;
            sum3_q  <= '0;
            cout3_q <= 1'b0;
            ovf3_q  <= 1'b0;
            tag3_q  <= '0;
        end else begin
            if (adv3) v3_q <= v2_q;
            if (adv3 && v2_q) begin
                sum3_q  <= sum_d;
                cout3_q <= cout_d;
                ovf3_q  <= ovf_d;
                tag3_q  <= tag2_q;
            end
        end
    end
endmodule

// File: tb/tb_bk_adder_pipe.sv
// tb_bk_adder_pipe: randomized scoreboard bench for bk_adder_pipe with directed corner cases and a width sweep
module tb_bk_adder_pipe;
    localparam int W = 12;
    localparam int T = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic srst = 1'b1;
    logic in_valid, in_ready, in_cin, in_sub, out_valid, out_ready, out_cout, out_ovf;
    logic [W-1:0] in_a, in_b, out_sum;
    logic [T-1:0] in_tag, out_tag;
    logic [129:0] act;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign act = {out_ovf, out_cout, 64'(out_sum), 64'(out_tag)};

    bk_adder_pipe #(.WIDTH(W), .TAG_W(T)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_cout(out_cout), .out_ovf(out_ovf), .out_tag(out_tag)
    );

    // Reference: plain integer arithmetic, signed overflow judged by range of the true signed result.
    function automatic logic [65:0] model(int w, longint unsigned a, longint unsigned b, bit cin, bit sub);
        longint unsigned m, s;
        longint sa, sb, sr, lo, hi;
        bit co;
        m  = (64'd1 << w) - 64'd1;
        sa = ((a >> (w - 1)) & 64'd1) != 0 ? longint'(a) - longint'(m) - 1 : longint'(a);
        sb = ((b >> (w - 1)) & 64'd1) != 0 ? longint'(b) - longint'(m) - 1 : longint'(b);
        hi = (longint'(1) << (w - 1)) - 1;
        lo = -hi - 1;
        if (sub) begin
            s  = (a - b) & m;
            co = a >= b;
            sr = sa - sb;
        end else begin
            s  = (a + b + 64'(cin)) & m;
            co = ((a + b + 64'(cin)) >> w) != 0;
            sr = sa + sb + longint'(cin);
        end
        return {(sr < lo) || (sr > hi), co, s};
    endfunction

    task automatic check(string nm, logic [129:0] a, logic [129:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, a, e);
        end
    endtask

    task automatic check_i(string nm, int a, int e);
        checks++;
        if (a != e) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, a, e);
        end
    endtask

    task automatic rand_in();
        in_a   = W'($urandom);
        in_b   = W'($urandom);
        in_cin = 1'($urandom);
        in_sub = 1'($urandom);
        in_tag = T'($urandom);
    endtask

    logic [129:0] q[$];
    logic stall = 1'b0;
    logic [129:0] hold;

    // Scoreboard for the main instance: push on accept, pop and compare on drain, hold check while stalled.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            stall = 1'b0;
        end else begin
            if (stall) check("stall_hold", act, hold);
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_result actual=%0h expected=none", act);
                end else begin
                    check("result", act, q.pop_front());
                end
            end
            if (in_valid && in_ready)
                q.push_back({model(W, 64'(in_a), 64'(in_b), in_cin, in_sub), 64'(in_tag)});
            stall = out_valid && !out_ready;
            hold  = act;
        end
    end

    for (genvar k = 0; k < 4; k++) begin : g_sw
        localparam int SW = (k == 0) ? 2 : (k == 1) ? 7 : (k == 2) ? 16 : 33;
        logic iv, ir, ic, is, ov, orr, oc, oo, it, ot;
        logic [SW-1:0] ia, ib, os;
        logic [129:0] sq[$];
        bit done = 1'b0;

        bk_adder_pipe #(.WIDTH(SW), .TAG_W(1)) dut_s (
            .clk(clk), .rst(srst), .in_valid(iv), .in_ready(ir),
            .in_a(ia), .in_b(ib), .in_cin(ic), .in_sub(is), .in_tag(it),
            .out_valid(ov), .out_ready(orr), .out_sum(os),
            .out_cout(oc), .out_ovf(oo), .out_tag(ot)
        );

        always @(negedge clk) begin
            if (!srst) begin
                if (ov && orr) begin
                    if (sq.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL sweep_w%0d_unexpected actual=%0h expected=none", SW, os);
                    end else begin
                        check($sformatf("sweep_w%0d", SW), {oo, oc, 64'(os), 64'(ot)}, sq.pop_front());
                    end
                end
                if (iv && ir) sq.push_back({model(SW, 64'(ia), 64'(ib), ic, is), 64'(it)});
            end
        end

        initial begin
            iv = 1'b0; orr = 1'b0; ia = '0; ib = '0; ic = 1'b0; is = 1'b0; it = 1'b0;
            @(negedge srst);
            @(posedge clk); #1;
            repeat (300) begin
                iv  = $urandom_range(0, 3) != 0;
                orr = $urandom_range(0, 3) != 0;
                ia  = SW'({$urandom, $urandom});
                ib  = SW'({$urandom, $urandom});
                ic  = 1'($urandom);
                is  = 1'($urandom);
                it  = 1'($urandom);
                @(posedge clk); #1;
            end
            iv  = 1'b0;
            orr = 1'b1;
            repeat (6) begin @(posedge clk); #1; end
            check_i($sformatf("sweep_w%0d_drain", SW), sq.size(), 0);
            done = 1'b1;
        end
    end

    task automatic directed(logic [W-1:0] a, logic [W-1:0] b, logic cin, logic sub, logic [T-1:0] tag,
                            logic [W-1:0] es, logic ec, logic eo);
        in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_tag = tag; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check_i("latency_early", int'(out_valid), 0);
        @(posedge clk); #1;
        check_i("latency_valid", int'(out_valid), 1);
        check("directed", act, {eo, ec, 64'(es), 64'(tag)});
        @(posedge clk); #1;
    endtask

    initial begin
        int acc, seq, drops, stale, n;
        in_valid = 1'b0; out_ready = 1'b1; in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0; in_tag = '0;
        #2;
        check("reset_state", {out_valid, act}, '0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        srst = 1'b0;
        check_i("in_ready_after_reset", int'(in_ready), 1);

        check("model_wrap", 130'(model(12, 'hFFF, 'h001, 0, 0)), 130'({1'b0, 1'b1, 64'h0}));
        check("model_ovf_add", 130'(model(12, 'h7FF, 'h001, 0, 0)), 130'({1'b1, 1'b0, 64'h800}));
        check("model_sub_neg", 130'(model(12, 'h005, 'h007, 0, 1)), 130'({1'b0, 1'b0, 64'hFFE}));
        check("model_min_m1", 130'(model(12, 'h800, 'h001, 0, 1)), 130'({1'b1, 1'b1, 64'h7FF}));
        check("model_eq", 130'(model(12, 'h3A5, 'h3A5, 1, 1)), 130'({1'b0, 1'b1, 64'h0}));

        directed('hFFF, 'h001, 1'b0, 1'b0, 4'h1, 'h000, 1'b1, 1'b0);
        directed('h7FF, 'h001, 1'b0, 1'b0, 4'h2, 'h800, 1'b0, 1'b1);
        directed('h005, 'h007, 1'b0, 1'b1, 4'h3, 'hFFE, 1'b0, 1'b0);
        directed('h800, 'h001, 1'b1, 1'b1, 4'h4, 'h7FF, 1'b1, 1'b1);
        directed('h3A5, 'h3A5, 1'b0, 1'b1, 4'h5, 'h000, 1'b1, 1'b0);

        drops = 0;
        for (int i = 0; i < 100; i++) begin
            rand_in();
            in_valid = 1'b1;
            @(negedge clk);
            if (!in_ready) drops++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check_i("stream_in_ready", drops, 0);
        repeat (4) begin @(posedge clk); #1; end
        check_i("stream_drain", q.size(), 0);

        out_ready = 1'b0;
        in_valid  = 1'b1;
        acc = 0;
        repeat (5) begin
            rand_in();
            @(negedge clk);
            if (in_ready) acc++;
            @(posedge clk); #1;
        end
        check_i("bp_accepts", acc, 3);
        check_i("bp_in_ready", int'(in_ready), 0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        seq = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            seq = seq * 2 + int'(out_valid);
            @(posedge clk); #1;
        end
        check_i("bp_drain_pattern", seq, 14);
        check_i("bp_drain_empty", q.size(), 0);

        out_ready = 1'b0;
        in_valid  = 1'b1;
        repeat (3) begin
            rand_in();
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check_i("rst_pipe_full", int'(out_valid), 1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_clear", {out_valid, act}, '0);
        @(posedge clk); #3;
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        check_i("rst_in_ready", int'(in_ready), 1);
        @(posedge clk); #1;
        stale = 0;
        repeat (4) begin
            @(negedge clk);
            if (out_valid) stale++;
            @(posedge clk); #1;
        end
        check_i("rst_no_stale", stale, 0);
        for (int i = 0; i < 20; i++) begin
            rand_in();
            in_valid  = 1'b1;
            out_ready = $urandom_range(0, 3) != 0;
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (6) begin @(posedge clk); #1; end
        check_i("post_rst_drain", q.size(), 0);

        n = 0;
        while (!(g_sw[0].done && g_sw[1].done && g_sw[2].done && g_sw[3].done) && n < 5000) begin
            @(posedge clk);
            n++;
        end
        check_i("sweep_done", int'(g_sw[0].done && g_sw[1].done && g_sw[2].done && g_sw[3].done), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
